// File: rtl/pre_decoder_2_4.sv
`default_nettype none
// ============================================================================
//  Module      : pre_decoder_2_4
//  Description : 2-to-4 one-hot pre-decoder with registered copy, change pulse
//                and optional decode coverage (macro PREDECODER_COVERAGE_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module pre_decoder_2_4 #(
    parameter int ACTIVE_LOW = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in,
    output logic [3:0]       out,
    output logic [3:0]       out_q,
    output logic             chg,
    output logic [3:0]       cov_mask,
    output logic             all_seen,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [3:0] c_INV_MASK = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [3:0] w_onehot;
    logic [3:0] w_out;
    logic       w_change;

    logic [3:0] r_out_q;
    logic       r_chg;
    logic [1:0] r_prev;
    logic       r_first;

    assign w_onehot = 4'b0001 << in;
    assign w_out    = w_onehot ^ c_INV_MASK;
    assign out      = w_out;

    // The cycle right after reset release compares against a code captured
    // while in reset, so it is never treated as a change.
    assign w_change = (in != r_prev) && !r_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= c_INV_MASK;
            r_chg   <= 1'b0;
            r_prev  <= in;
            r_first <= 1'b1;
        end else begin
            r_out_q <= w_out;
            r_chg   <= w_change;
            r_prev  <= in;
            r_first <= 1'b0;
        end
    end

    assign out_q = r_out_q;
    assign chg   = r_chg;

`ifdef PREDECODER_COVERAGE_EN
    localparam logic [CNT_W-1:0] c_HIT_MAX = '1;

    logic [3:0]       r_cov;
    logic [CNT_W-1:0] r_hit;

    // Coverage tracks the un-inverted decode regardless of output polarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cov <= 4'h0;
            r_hit <= '0;
        end else begin
            r_cov <= r_cov | w_onehot;
            if (w_change && (r_hit != c_HIT_MAX)) begin
                r_hit <= r_hit + CNT_W'(1);
            end
        end
    end

    assign cov_mask = r_cov;
    assign all_seen = (r_cov == 4'hF);
    assign hit_cnt  = r_hit;
`else
    assign cov_mask = 4'h0;
    assign all_seen = 1'b0;
    assign hit_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pre_decoder_2_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pre_decoder_2_4
//  Description : Scoreboard bench for pre_decoder_2_4 (default and
//                ACTIVE_LOW=1 / CNT_W=2 instances driven in parallel).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pre_decoder_2_4;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [1:0] in;

    logic [3:0] out1, oq1, cov1;
    logic       chg1, all1;
    logic [7:0] hit1;

    logic [3:0] out2, oq2, cov2;
    logic       chg2, all2;
    logic [1:0] hit2;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] out;
        logic [3:0] oq;
        logic       chg;
        logic [3:0] cov;
        logic [7:0] hit;
        logic [1:0] hit2;
    } exp_t;

    exp_t sb[$];

    pre_decoder_2_4 #(.ACTIVE_LOW(0), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in(in),
        .out(out1), .out_q(oq1), .chg(chg1),
        .cov_mask(cov1), .all_seen(all1), .hit_cnt(hit1)
    );

    pre_decoder_2_4 #(.ACTIVE_LOW(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in(in),
        .out(out2), .out_q(oq2), .chg(chg2),
        .cov_mask(cov2), .all_seen(all2), .hit_cnt(hit2)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One stimulus cycle: inputs change on the falling edge, the expectation
    // for the state after the following rising edge goes to the scoreboard.
    task automatic cyc(input logic r, input logic [1:0] v, input logic [3:0] e_oq,
                       input logic e_chg, input logic [7:0] e_hit,
                       input logic [3:0] e_cov, input logic [1:0] e_hit2);
        exp_t e;
        @(negedge clk);
        rst = r;
        in  = v;
        e.out = 4'b0001 << v;
        e.oq  = e_oq;
        e.chg = e_chg;
`ifdef PREDECODER_COVERAGE_EN
        e.cov  = e_cov;
        e.hit  = e_hit;
        e.hit2 = e_hit2;
`else
        e.cov  = 4'h0;
        e.hit  = 8'h0;
        e.hit2 = 2'h0;
`endif
        sb.push_back(e);
    endtask

    // Monitor: every rising edge presents a new registered result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out",       {4'h0, out1}, {4'h0, e.out});
                chk("out_al",    {4'h0, out2}, {4'h0, ~e.out});
                chk("out_q",     {4'h0, oq1},  {4'h0, e.oq});
                chk("out_q_al",  {4'h0, oq2},  {4'h0, ~e.oq});
                chk("chg",       {7'h0, chg1}, {7'h0, e.chg});
                chk("chg_al",    {7'h0, chg2}, {7'h0, e.chg});
                chk("cov_mask",  {4'h0, cov1}, {4'h0, e.cov});
                chk("cov_al",    {4'h0, cov2}, {4'h0, e.cov});
                chk("all_seen",  {7'h0, all1}, {7'h0, (e.cov == 4'hF)});
                chk("all_al",    {7'h0, all2}, {7'h0, (e.cov == 4'hF)});
                chk("hit_cnt",   hit1,         e.hit);
                chk("hit_cnt_2", {6'h0, hit2}, {6'h0, e.hit2});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] sweep_exp [4];
        logic [3:0] lit;
        sweep_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst    = 1'b0;
        in     = 2'b00;

        // Combinational decode with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            in = 2'(i);
            #1;
            chk("sweep_out", {4'h0, out1}, {4'h0, sweep_exp[i]});
        end
        lit = 4'd10;
        in  = lit[1:0];
        #1;
        chk("trunc_out", {4'h0, out1}, 8'h04);
        chk("al_out_10", {4'h0, out2}, 8'h0B);

        clk_en = 1'b1;
        //   rst in    out_q    chg hit cov      hit2
        cyc(1, 2'b00, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(1, 2'b01, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(0, 2'b01, 4'b0010, 0, 0, 4'b0010, 0);
        cyc(0, 2'b01, 4'b0010, 0, 0, 4'b0010, 0);
        cyc(0, 2'b01, 4'b0010, 0, 0, 4'b0010, 0);
        cyc(1, 2'b00, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(0, 2'b00, 4'b0001, 0, 0, 4'b0001, 0);
        cyc(0, 2'b01, 4'b0010, 1, 1, 4'b0011, 1);
        cyc(0, 2'b10, 4'b0100, 1, 2, 4'b0111, 2);
        cyc(0, 2'b11, 4'b1000, 1, 3, 4'b1111, 3);
        cyc(0, 2'b00, 4'b0001, 1, 4, 4'b1111, 3);
        cyc(0, 2'b11, 4'b1000, 1, 5, 4'b1111, 3);
        cyc(0, 2'b11, 4'b1000, 0, 5, 4'b1111, 3);
        // reset coinciding with an input change
        cyc(1, 2'b10, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(0, 2'b11, 4'b1000, 0, 0, 4'b1000, 0);
        // ten toggles: narrow counter pins at 3
        cyc(0, 2'b10, 4'b0100, 1, 1,  4'b1100, 1);
        cyc(0, 2'b11, 4'b1000, 1, 2,  4'b1100, 2);
        cyc(0, 2'b10, 4'b0100, 1, 3,  4'b1100, 3);
        cyc(0, 2'b11, 4'b1000, 1, 4,  4'b1100, 3);
        cyc(0, 2'b10, 4'b0100, 1, 5,  4'b1100, 3);
        cyc(0, 2'b11, 4'b1000, 1, 6,  4'b1100, 3);
        cyc(0, 2'b10, 4'b0100, 1, 7,  4'b1100, 3);
        cyc(0, 2'b11, 4'b1000, 1, 8,  4'b1100, 3);
        cyc(0, 2'b10, 4'b0100, 1, 9,  4'b1100, 3);
        cyc(0, 2'b11, 4'b1000, 1, 10, 4'b1100, 3);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pre_decoder_2_4.md
PRE_DECODER_2_4 -- requirements
Module: pre_decoder_2_4

Interface
REQ-001 The parameter ACTIVE_LOW SHALL default to 0; when 1, all decoded outputs (out, out_q) SHALL be bitwise inverted, so the selected line is 0.
REQ-002 The parameter CNT_W SHALL default to 8 and set the width of hit_cnt.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  2  binary select code.
REQ-006 out  output  4  combinational one-hot decode of in.
REQ-007 out_q  output  4  registered copy of the decode.
REQ-008 chg  output  1  registered pulse: the code differs from the previous cycle's code.
REQ-009 cov_mask  output  4  sticky record of the codes decoded since reset.
REQ-010 all_seen  output  1  high when cov_mask == 4'b1111.
REQ-011 hit_cnt  output  CNT_W  count of code changes since reset, saturating.

Function
REQ-012 out SHALL equal 4'b0001 << in, with zero latency and no dependence on clk or rst:
- 00 -> 0001
- 01 -> 0010
- 10 -> 0100
- 11 -> 1000
REQ-013 Exactly one bit of out SHALL be active for every in value; in carrying X/Z is outside scope.
REQ-014 out_q SHALL load the value of out on every rising clk edge when rst is low (1-cycle latency).
REQ-015 A 2-bit register prev SHALL capture in every cycle.
REQ-016 chg SHALL be registered (in != prev) and SHALL be 0 in the first cycle after reset release.
REQ-017 Each cycle, cov_mask SHALL OR in the un-inverted one-hot decode of in; bits SHALL never clear except on reset.
REQ-018 all_seen SHALL be combinational from cov_mask.
REQ-019 hit_cnt SHALL increment by 1 on each cycle where in != prev, except the first cycle after reset.
REQ-020 hit_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-021 Simultaneous rst and an input change: reset SHALL take priority.

Reset
REQ-022 While rst is high at a clk edge, the following SHALL be set:
- out_q to the inactive pattern (0000, or 1111 if ACTIVE_LOW)
- chg to 0
- cov_mask to 0000
- hit_cnt to 0
- prev to the current in, with a first-cycle flag set
REQ-023 out SHALL be unaffected by rst.
REQ-024 Reset asserted mid-operation SHALL clear state on the next edge regardless of activity.

Configuration
REQ-025 With macro PREDECODER_COVERAGE_EN defined, cov_mask, all_seen and hit_cnt SHALL be implemented as specified.
REQ-026 Without PREDECODER_COVERAGE_EN:
- cov_mask, all_seen and hit_cnt SHALL be tied to 0 with no associated registers.
- out, out_q and chg behaviour SHALL be unchanged.

Verification
REQ-027 Sweep in = 00, 01, 10, 11 at 1 ns steps with no clock -> out = 0001, 0010, 0100, 1000, each settling within the step.
REQ-028 Drive the literal 2'd10 (truncates to 2'b10) -> out = 0100.
REQ-029 Reset, then in = 01 held 3 cycles -> out_q = 0010 one cycle after release; chg stays 0; hit_cnt = 0.
REQ-030 With the macro defined, apply codes 00, 01, 10, 11 one per cycle:
- cov_mask reaches 1111 and all_seen = 1
- hit_cnt = 3
- a mid-run rst clears both.
REQ-031 With CNT_W = 2, toggle in every cycle for 10 cycles -> hit_cnt saturates at 3.
REQ-032 With ACTIVE_LOW = 1 and in = 10 -> out = 1011; out_q after reset = 1111.
